z80_bus_arbiter: RTL and testbench
==================================

Name: z80_bus_arbiter

Overview:
- Generates the master-select (msel) consumed by the system bus multiplexer.
- Master 0 is always the Z80 CPU and is the default bus owner. Masters 1..MASTER_QTY-1 are secondary masters (DMA, debug) that request the bus.
- Uses the CPU BUSREQ_n/BUSACK_n handshake to take the bus from the CPU, grants one secondary master at a time in round-robin order, then returns the bus to the CPU.
- One clock domain; the bus is always handed back to the CPU between secondary grants.

Parameters:
- MASTER_QTY, 2, total master count including CPU at index 0; legal range 1..16.
- MAX_HOLD, 0, maximum consecutive GRANT cycles per secondary tenure; 0 = unlimited.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- req  input  MASTER_QTY  bus request per master, level; req[0] ignored
- gnt  output  MASTER_QTY  one-hot grant; gnt[0] = CPU owns bus
- msel  output  max($clog2(MASTER_QTY),1)  mux select index, to sysmux msel
- busreq_n  output  1  to CPU BUSREQ_n, active low
- busack_n  input  1  from CPU BUSACK_n, active low, already synchronous to clk
- busy  output  1  high in any state other than IDLE

Behaviour:
- Interface: one clock (clk); reset_n is synchronous and active-low. All outputs are registered.
- Reset (reset_n=0 at a clk edge) forces these values, regardless of state:
  - state=IDLE, busreq_n=1, msel=0, gnt=1 (only gnt[0] set), busy=0
  - hold counter=0
  - last_winner=MASTER_QTY-1, so master 1 has first priority
- Reset mid-tenure drops the secondary grant immediately and releases busreq_n.
- States:
  - IDLE: CPU owns the bus. If any req[i] with i≥1 is high, the round-robin winner is the first requesting index after last_winner, searching upward and wrapping 1..MASTER_QTY-1. Latch the winner into pend and drive busreq_n<=0 → REQ.
  - REQ: hold busreq_n=0 and gnt[0]=1.
    - If req[pend]=0: abort, busreq_n<=1 → RELEASE.
    - Else if busack_n=0: msel<=pend, gnt<=one-hot(pend), last_winner<=pend, hold counter<=0 → GRANT.
    - Abort has priority when both occur in the same cycle.
  - GRANT: secondary owns the bus; busreq_n stays 0.
    - Release condition: req[pend]=0, or (MAX_HOLD≠0 and hold counter = MAX_HOLD-1).
    - On release: msel<=0, gnt<=0 (all bits), busreq_n<=1 → RELEASE.
    - Otherwise increment the hold counter, saturating.
  - RELEASE: gnt=0, msel=0, busreq_n=1.
    - When busack_n=1: gnt<=1 → IDLE.
    - New requests are not evaluated until IDLE.
- Latency:
  - req rise in IDLE → busreq_n low on the next edge.
  - busack_n low sampled in REQ → gnt/msel valid on the next edge.
  - Minimum req-to-grant is 2 cycles after busack_n asserts with zero CPU delay.
- msel always equals the index of the single set gnt bit. msel is 0 whenever gnt=0.
- gnt is one-hot or all-zero. It is all-zero only in RELEASE and in the abort path from REQ.
- A timed-out master that keeps req high is re-queued normally. Round-robin selects other requesters first.
- MASTER_QTY=1: the FSM never leaves IDLE; busreq_n=1, msel=0, gnt=1 permanently.
- busack_n low while in IDLE (spurious) is ignored.

Test Plan:
1. Reset, MASTER_QTY=3, all req=0 → busreq_n=1, msel=0, gnt=3'b001, busy=0, held for 20 cycles.
2. Single request:
   - Stimulus: req[1]=1; CPU model pulls busack_n low 3 cycles after busreq_n falls.
   - Required: busreq_n low 1 cycle after req; gnt=3'b010 and msel=1 one cycle after busack_n low.
   - Then drop req[1]: next edge gnt=0, msel=0, busreq_n=1; busack_n high → gnt=3'b001.
3. Round-robin: req[1] and req[2] both held high continuously, MAX_HOLD=8 → tenures alternate 1,2,1,2, each exactly 8 GRANT cycles, with gnt[0] between each tenure.
4. Abort: req[2] pulses for 2 cycles, before busack_n asserts → transitions REQ→RELEASE, gnt never shows bit 2; returns to IDLE after busack_n high.
5. Reset mid-GRANT (msel=2) → after the reset edge msel=0, gnt=3'b001, busreq_n=1, state IDLE; the next req[1] is serviced before req[2].
6. MASTER_QTY=1: toggle req[0] and busack_n randomly for 100 cycles → busreq_n stays 1, msel stays 0, gnt stays 1.

Source files
------------

// File: rtl/z80_bus_arbiter_if.sv
// Bus-ownership signal bundle between the Z80 bus arbiter and its surroundings
// (secondary masters, CPU BUSREQ_n/BUSACK_n pins, system bus multiplexer).
//
// Handshake: req[i] is a level held by master i for as long as it wants the bus.
// gnt is one-hot (or all-zero while ownership changes hands), and msel always
// carries the index of the set gnt bit (0 when gnt is all-zero). busreq_n and
// busack_n follow the Z80 protocol: the arbiter pulls busreq_n low and the CPU
// answers with busack_n low once it has floated its bus. The arbiter only grants
// a secondary master while both are low. It hands the bus back by raising
// busreq_n and waits for busack_n high before gnt[0] is set again.
interface z80_bus_arbiter_if #(
    parameter int MASTER_QTY = 2
) ();
    localparam int IW = ($clog2(MASTER_QTY) > 1) ? $clog2(MASTER_QTY) : 1;

    logic [MASTER_QTY-1:0] req;
    logic [MASTER_QTY-1:0] gnt;
    logic [IW-1:0]         msel;
    logic                  busreq_n;
    logic                  busack_n;
    logic                  busy;
    logic [1:0]            dbg_state;

    // Arbiter side: drives grant/select/CPU request, observes requests and CPU ack
    modport master (
        input  req,
        input  busack_n,
        output gnt,
        output msel,
        output busreq_n,
        output busy,
        output dbg_state
    );

    // Environment side: requesting masters, CPU and bus multiplexer
    modport slave (
        output req,
        output busack_n,
        input  gnt,
        input  msel,
        input  busreq_n,
        input  busy,
        input  dbg_state
    );
endinterface

// File: rtl/z80_bus_arbiter.sv
// Z80 system bus arbiter. The CPU (master 0) owns the bus by default. Secondary
// masters are served one tenure at a time in round-robin order. The bus goes
// back to the CPU after every tenure, using the BUSREQ_n/BUSACK_n handshake.
// All outputs are registered.
module z80_bus_arbiter #(
    parameter int MASTER_QTY = 2,
    parameter int MAX_HOLD   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    z80_bus_arbiter_if.master bus
);
    localparam int IW  = ($clog2(MASTER_QTY) > 1) ? $clog2(MASTER_QTY) : 1;
    localparam int HW  = ($clog2(MAX_HOLD) > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int SEC = (MASTER_QTY > 1) ? MASTER_QTY - 1 : 1;
    localparam int PW  = 1 << IW;

    localparam logic [HW-1:0]         HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [MASTER_QTY-1:0] GNT_CPU   = MASTER_QTY'(1);
    localparam logic [IW-1:0]         LAST_RST  = IW'(MASTER_QTY - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_GRANT   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         pend_q, pend_d;
    logic [IW-1:0]         last_q, last_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [MASTER_QTY-1:0] gnt_q, gnt_d;
    logic [IW-1:0]         msel_q, msel_d;
    logic                  busreq_n_q, busreq_n_d;
    logic                  busy_q, busy_d;

    // Request vector padded to a power of two so any IW-bit index is in range
    logic [PW-1:0]         req_pad;
    logic                  win_found;
    logic [IW-1:0]         win_idx;
    logic                  pend_req;
    logic                  release_now;
    logic [MASTER_QTY-1:0] pend_onehot;

    // Zero-extend the request vector; padding bits never request
    always_comb begin
        req_pad = '0;
        req_pad[MASTER_QTY-1:0] = bus.req;
    end

    // Round-robin search: first requester after last_winner, wrapping over 1..MASTER_QTY-1
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k < MASTER_QTY; k++) begin
            cand = ((int'(last_q) - 1 + k) % SEC) + 1;
            if (!win_found && req_pad[IW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IW'(cand);
            end
        end
    end

    // Pending-master status, tenure end condition and one-hot grant of the pending master
    always_comb begin
        pend_req    = req_pad[pend_q];
        release_now = !pend_req || ((MAX_HOLD != 0) && (hold_q == HOLD_LAST));
        pend_onehot = '0;
        for (int i = 0; i < MASTER_QTY; i++) begin
            pend_onehot[i] = (IW'(i) == pend_q);
        end
    end

    // State register plus registered outputs; reset drops any tenure at once
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            pend_q     <= '0;
            last_q     <= LAST_RST;
            hold_q     <= '0;
            gnt_q      <= GNT_CPU;
            msel_q     <= '0;
            busreq_n_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            last_q     <= last_d;
            hold_q     <= hold_d;
            gnt_q      <= gnt_d;
            msel_q     <= msel_d;
            busreq_n_q <= busreq_n_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic; abort in REQ wins over a simultaneous CPU acknowledge
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (!pend_req) begin
                    state_d = S_RELEASE;
                end else if (!bus.busack_n) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (release_now) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (bus.busack_n) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and bookkeeping registers
    always_comb begin
        pend_d     = pend_q;
        last_d     = last_q;
        hold_d     = hold_q;
        gnt_d      = gnt_q;
        msel_d     = msel_q;
        busreq_n_d = busreq_n_q;
        case (state_q)
            S_IDLE: begin
                gnt_d      = GNT_CPU;
                msel_d     = '0;
                busreq_n_d = 1'b1;
                if (win_found) begin
                    pend_d     = win_idx;
                    busreq_n_d = 1'b0;
                end
            end
            S_REQ: begin
                if (!pend_req) begin
                    gnt_d      = '0;
                    msel_d     = '0;
                    busreq_n_d = 1'b1;
                end else if (!bus.busack_n) begin
                    gnt_d  = pend_onehot;
                    msel_d = pend_q;
                    last_d = pend_q;
                    hold_d = '0;
                end
            end
            S_GRANT: begin
                if (release_now) begin
                    gnt_d      = '0;
                    msel_d     = '0;
                    busreq_n_d = 1'b1;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_RELEASE: begin
                gnt_d      = '0;
                msel_d     = '0;
                busreq_n_d = 1'b1;
                if (bus.busack_n) begin
                    gnt_d = GNT_CPU;
                end
            end
            default: begin
                gnt_d      = GNT_CPU;
                msel_d     = '0;
                busreq_n_d = 1'b1;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign bus.gnt       = gnt_q;
    assign bus.msel      = msel_q;
    assign bus.busreq_n  = busreq_n_q;
    assign bus.busy      = busy_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Bench for z80_bus_arbiter: a 3-master instance (MAX_HOLD=8) and a CPU-only
// instance. Every change of the observable outputs is an event
// {gnt, msel, busreq_n, busy, cycle}. The stimulus queues the events it expects,
// and the monitors compare each event against that queue.
module tb_z80_bus_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    z80_bus_arbiter_if #(.MASTER_QTY(3)) bus3 ();
    z80_bus_arbiter_if #(.MASTER_QTY(1)) bus1 ();

    z80_bus_arbiter #(.MASTER_QTY(3), .MAX_HOLD(8)) dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus3)
    );

    z80_bus_arbiter #(.MASTER_QTY(1), .MAX_HOLD(0)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    // Clock edge counter: value read at a negedge = number of posedges so far
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [22:0] exp_q[$];
    logic [22:0] exp1_q[$];
    int n_vec = 0;
    int n_err = 0;
    logic cpu_spurious;

    function automatic logic [22:0] ev(input logic [2:0] g, input logic [1:0] m,
                                       input logic brq, input logic bsy, input int unsigned c);
        return {g, m, brq, bsy, c[15:0]};
    endfunction

    function automatic string fmt(input logic [22:0] e);
        return $sformatf("gnt=%b msel=%0d busreq_n=%b busy=%b cyc=%0d",
                         e[22:20], e[19:18], e[17], e[16], e[15:0]);
    endfunction

    task automatic push_idle(input int unsigned c);
        exp_q.push_back(ev(3'b001, 2'd0, 1'b1, 1'b0, c));
    endtask

    task automatic push_req(input int unsigned c);
        exp_q.push_back(ev(3'b001, 2'd0, 1'b0, 1'b1, c));
    endtask

    task automatic push_grant(input logic [1:0] m, input int unsigned c);
        exp_q.push_back(ev((m == 2'd2) ? 3'b100 : 3'b010, m, 1'b0, 1'b1, c));
    endtask

    task automatic push_rel(input int unsigned c);
        exp_q.push_back(ev(3'b000, 2'd0, 1'b1, 1'b1, c));
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // CPU model: acknowledges on the 3rd negedge that sees busreq_n low, releases at once
    initial begin
        int lo_cnt;
        lo_cnt = 0;
        bus3.busack_n = 1'b1;
        forever begin
            @(negedge clk);
            if (cpu_spurious) begin
                bus3.busack_n = 1'b0;
            end else if (bus3.busreq_n !== 1'b0) begin
                lo_cnt = 0;
                bus3.busack_n = 1'b1;
            end else begin
                if (lo_cnt < 1000) lo_cnt++;
                if (lo_cnt >= 3) bus3.busack_n = 1'b0;
            end
        end
    end

    // Monitor for the 3-master arbiter
    initial begin
        logic [6:0]  prev;
        logic [6:0]  now;
        logic [22:0] got;
        logic [22:0] exp;
        prev = 'x;
        forever begin
            @(negedge clk);
            now = {bus3.gnt, bus3.msel, bus3.busreq_n, bus3.busy};
            if (now !== prev) begin
                got = {now, cyc[15:0]};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL arb3 unexpected event: got %s", fmt(got));
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_err++;
                        $display("FAIL arb3 event: got %s, expected %s", fmt(got), fmt(exp));
                    end
                end
                prev = now;
            end
        end
    end

    // Monitor for the CPU-only arbiter
    initial begin
        logic [6:0]  prev;
        logic [6:0]  now;
        logic [22:0] got;
        logic [22:0] exp;
        prev = 'x;
        forever begin
            @(negedge clk);
            now = {2'b00, bus1.gnt, 1'b0, bus1.msel, bus1.busreq_n, bus1.busy};
            if (now !== prev) begin
                got = {now, cyc[15:0]};
                n_vec++;
                if (exp1_q.size() == 0) begin
                    n_err++;
                    $display("FAIL arb1 unexpected event: got %s", fmt(got));
                end else begin
                    exp = exp1_q.pop_front();
                    if (got !== exp) begin
                        n_err++;
                        $display("FAIL arb1 event: got %s, expected %s", fmt(got), fmt(exp));
                    end
                end
                prev = now;
            end
        end
    end

    // Directed stimulus
    initial begin
        int unsigned c;
        int unsigned b;
        logic [1:0]  m;
        logic [22:0] left;

        reset_n       = 1'b0;
        cpu_spurious  = 1'b0;
        bus3.req      = '0;
        bus1.req      = '0;
        bus1.busack_n = 1'b1;

        // Reset state appears at the first edge and must hold through 20 idle cycles
        push_idle(1);
        exp1_q.push_back(ev(3'b001, 2'd0, 1'b1, 1'b0, 1));
        step(3);
        reset_n = 1'b1;
        step(20);

        // Single request from master 1, then drop it
        c = cyc;
        bus3.req[1] = 1'b1;
        push_req(c + 1);
        push_grant(2'd1, c + 4);
        step(6);
        bus3.req[1] = 1'b0;
        push_rel(c + 7);
        push_idle(c + 8);
        step(4);

        // Spurious busack_n low in IDLE must be ignored
        cpu_spurious = 1'b1;
        step(4);
        cpu_spurious = 1'b0;
        step(3);

        // Round-robin with 8-cycle tenures; last winner was 1, so 2 goes first
        c = cyc;
        bus3.req = 3'b110;
        for (int k = 0; k < 4; k++) begin
            b = c + 13 * k;
            m = (k % 2 == 0) ? 2'd2 : 2'd1;
            push_req(b + 1);
            push_grant(m, b + 4);
            push_rel(b + 12);
            push_idle(b + 13);
        end
        step(52);
        bus3.req = 3'b000;
        step(4);

        // Abort: req[2] for 2 cycles, gone before the CPU acknowledges
        c = cyc;
        bus3.req[2] = 1'b1;
        push_req(c + 1);
        step(2);
        bus3.req[2] = 1'b0;
        push_rel(c + 3);
        push_idle(c + 4);
        step(4);

        // Abort coinciding with the acknowledge: abort must win
        c = cyc;
        bus3.req[2] = 1'b1;
        push_req(c + 1);
        step(3);
        bus3.req[2] = 1'b0;
        push_rel(c + 4);
        push_idle(c + 5);
        step(4);

        // Reset in the middle of master 2's tenure; afterwards master 1 wins first
        c = cyc;
        bus3.req = 3'b100;
        push_req(c + 1);
        push_grant(2'd2, c + 4);
        step(6);
        reset_n  = 1'b0;
        bus3.req = 3'b110;
        push_idle(c + 7);
        step(1);
        reset_n = 1'b1;
        push_req(c + 8);
        push_grant(2'd1, c + 11);
        step(5);
        bus3.req = 3'b000;
        push_rel(c + 13);
        push_idle(c + 14);
        step(4);

        // CPU-only arbiter: random req[0]/busack_n must never move it out of IDLE
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus1.req      = 1'($urandom_range(0, 1));
            bus1.busack_n = 1'($urandom_range(0, 1));
        end
        step(3);

        // Events expected but never seen
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            left = exp_q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL arb3 missing event: got none, expected %s", fmt(left));
        end
        while (exp1_q.size() > 0) begin
            left = exp1_q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL arb1 missing event: got none, expected %s", fmt(left));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
